// File: rtl/if_stage_fetchq_if.sv
// Split request/response instruction memory port.
// The fetch stage is the master; the instruction memory is the slave.
interface if_stage_fetchq_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/if_stage_fetchq.sv
// Instruction-fetch stage with up to MAX_OUT outstanding memory requests and an
// FQ_DEPTH-entry instruction queue to ID; redirects flush and discard stale responses.
module if_stage_fetchq #(
  parameter logic [31:0] PC_RESET = 32'h1C00_0000,
  parameter int          FQ_DEPTH = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ds_allowin,
  input  logic                     br_taken,
  input  logic [31:0]              br_target,
  output logic                     fs_to_ds_valid,
  output logic [64:0]              fs_to_ds_bus,
  if_stage_fetchq_if.master        inst_sram
);

  localparam int OCW = $clog2(MAX_OUT) + 1;
  localparam int QCW = $clog2(FQ_DEPTH) + 1;
  localparam int QPW = $clog2(FQ_DEPTH);
  localparam int PPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW  = QCW + 1;

  typedef struct packed {
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  logic [31:0]    pf_pc;
  logic [31:0]    hold_addr;
  logic           hold;
  logic           stale_hold;
  logic           adef_wait;
  logic [OCW-1:0] out_cnt;
  logic [OCW-1:0] disc_cnt;
  logic [OCW-1:0] out_cnt_nxt;
  logic [OCW-1:0] disc_cnt_nxt;
  logic [OCW-1:0] live_cnt;
  logic [31:0]    pend_pc [MAX_OUT];
  logic [PPW-1:0] pend_wptr;
  logic [PPW-1:0] pend_rptr;
  fq_entry_t      fq_mem [FQ_DEPTH];
  logic [QPW-1:0] fq_wptr;
  logic [QPW-1:0] fq_rptr;
  logic [QCW-1:0] fq_count;
  logic [SW-1:0]  fill;
  logic           issue_ok;
  logic           req;
  logic           acc;
  logic           rsp;
  logic           data_push;
  logic           adef_push;
  logic           fq_push;
  logic           fq_pop;
  fq_entry_t      push_entry;

  function automatic logic [PPW-1:0] pend_inc(input logic [PPW-1:0] p);
    return (p == PPW'(MAX_OUT - 1)) ? '0 : p + PPW'(1);
  endfunction

  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.wstrb = 4'h0;
  assign inst_sram.wdata = 32'h0;
  assign inst_sram.req   = req;
  assign inst_sram.addr  = hold ? hold_addr : pf_pc;
  assign fs_to_ds_bus    = fq_mem[fq_rptr];

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    live_cnt  = out_cnt - disc_cnt;
    fill      = SW'(fq_count) + SW'(live_cnt);
    // Reserve queue room for every current-stream response before issuing.
    issue_ok  = !hold && !adef_wait && (pf_pc[1:0] == 2'b00) &&
                (out_cnt < OCW'(MAX_OUT)) && (fill < SW'(FQ_DEPTH));
    // Held requests stay up regardless of the issue condition; nothing leaves during reset.
    req       = resetn && (hold || issue_ok);
    acc       = req && inst_sram.addr_ok;
    rsp       = resetn && inst_sram.data_ok && (out_cnt != '0);
    data_push = rsp && (disc_cnt == '0) && !br_taken;
    adef_push = resetn && !adef_wait && (pf_pc[1:0] != 2'b00) && (out_cnt == disc_cnt) &&
                (fq_count < QCW'(FQ_DEPTH)) && !br_taken;
    fq_push   = data_push || adef_push;

    fs_to_ds_valid = resetn && (fq_count != '0) && !br_taken;
    fq_pop         = fs_to_ds_valid && ds_allowin;

    out_cnt_nxt = out_cnt + OCW'(acc) - OCW'(rsp);
    if (br_taken) begin
      // Everything still in flight after this cycle belongs to the old stream.
      disc_cnt_nxt = out_cnt_nxt;
    end else begin
      disc_cnt_nxt = disc_cnt + OCW'(acc && stale_hold) - OCW'(rsp && (disc_cnt != '0));
    end

    if (data_push) begin
      push_entry.adef = 1'b0;
      push_entry.inst = inst_sram.rdata;
      push_entry.pc   = pend_pc[pend_rptr];
    end else begin
      push_entry.adef = 1'b1;
      push_entry.inst = 32'h0;
      push_entry.pc   = pf_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pf_pc      <= PC_RESET;
      hold_addr  <= PC_RESET;
      hold       <= 1'b0;
      stale_hold <= 1'b0;
      adef_wait  <= 1'b0;
      out_cnt    <= '0;
      disc_cnt   <= '0;
      pend_wptr  <= '0;
      pend_rptr  <= '0;
      fq_wptr    <= '0;
      fq_rptr    <= '0;
      fq_count   <= '0;
    end else begin
      out_cnt  <= out_cnt_nxt;
      disc_cnt <= disc_cnt_nxt;

      if (acc) pend_wptr <= pend_inc(pend_wptr);
      if (rsp) pend_rptr <= pend_inc(pend_rptr);

      if (acc)      hold <= 1'b0;
      else if (req) hold <= 1'b1;
      if (req && !hold) hold_addr <= pf_pc;

      // A request left hanging across a redirect is old-stream once it is finally accepted.
      if (acc)                  stale_hold <= 1'b0;
      else if (br_taken && req) stale_hold <= 1'b1;

      if (br_taken)                pf_pc <= br_target;
      else if (acc && !stale_hold) pf_pc <= pf_pc + 32'd4;

      if (br_taken)       adef_wait <= 1'b0;
      else if (adef_push) adef_wait <= 1'b1;

      if (br_taken) begin
        fq_wptr  <= '0;
        fq_rptr  <= '0;
        fq_count <= '0;
      end else begin
        if (fq_push) fq_wptr <= fq_wptr + QPW'(1);
        if (fq_pop)  fq_rptr <= fq_rptr + QPW'(1);
        fq_count <= fq_count + QCW'(fq_push) - QCW'(fq_pop);
      end
    end
  end

  // NOTE: storage arrays carry no reset; the counters and pointers alone say what is valid.
  always_ff @(posedge clk) begin
    if (acc)     pend_pc[pend_wptr] <= inst_sram.addr;
    if (fq_push) fq_mem[fq_wptr]    <= push_entry;
  end

endmodule

// File: tb/tb_if_stage_fetchq.sv
// Self-checking bench for if_stage_fetchq: in-order memory model plus an
// expected-entry scoreboard compared on every ID handshake.
module tb_if_stage_fetchq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;

  if_stage_fetchq_if sram ();

  if_stage_fetchq #(
    .PC_RESET (32'h1C00_0000),
    .FQ_DEPTH (4),
    .MAX_OUT  (2)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ds_allowin     (ds_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram      (sram)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          first_pop = -1;
  int          last_pop  = -1;
  int          rel;
  logic        accept_en, rsp_en, allow_en, run_en;
  logic        s_req, s_valid;
  logic [31:0] s_addr;
  logic [64:0] s_bus;
  logic        fired;
  logic [31:0] mem_q[$];
  logic [31:0] acc_log[$];
  logic [64:0] sb[$];

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (acc_log.size() > i) ? acc_log[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = base + 32'(4 * i);
      sb.push_back({1'b0, mem_data(pc), pc});
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, well before the rising edge.
  task automatic cycle(input logic br, input logic [31:0] tgt, input logic collide,
                       output logic did_br);
    logic do_br;
    @(negedge clk);
    resetn = run_en;
    do_br  = br || (collide && sram.req && accept_en && rsp_en && (mem_q.size() != 0));
    did_br = do_br;
    if (rsp_en && mem_q.size() != 0) begin
      sram.data_ok = 1'b1;
      sram.rdata   = mem_data(mem_q.pop_front());
    end else begin
      sram.data_ok = 1'b0;
      sram.rdata   = 32'h0;
    end
    sram.addr_ok = accept_en;
    br_taken     = do_br;
    br_target    = do_br ? tgt : 32'h0;
    ds_allowin   = allow_en && (sb.size() != 0);
    #1;
    s_req   = sram.req;
    s_addr  = sram.addr;
    s_valid = fs_to_ds_valid;
    s_bus   = fs_to_ds_bus;
    if (s_req && sram.addr_ok) begin
      mem_q.push_back(s_addr);
      acc_log.push_back(s_addr);
    end
    if (do_br) check("valid_in_br", 65'(s_valid), 65'(0));
    if (s_valid && ds_allowin) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      check("id_entry", s_bus, sb.pop_front());
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, f);
  endtask

  task automatic branch(input logic [31:0] tgt);
    logic f;
    cycle(1'b1, tgt, 1'b0, f);
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    logic f;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      cycle(1'b0, 32'h0, 1'b0, f);
      n++;
    end
    check(tag, 65'(sb.size()), 65'(0));
  endtask

  initial begin
    resetn = 1'b0; ds_allowin = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    sram.addr_ok = 1'b0; sram.data_ok = 1'b0; sram.rdata = 32'h0;
    accept_en = 1'b1; rsp_en = 1'b1; allow_en = 1'b1; run_en = 1'b0;

    // Reset state
    idle(3);
    check("rst_req",   65'(s_req),   65'(0));
    check("rst_valid", 65'(s_valid), 65'(0));
    check("rst_addr",  65'(s_addr),  65'(32'h1C00_0000));

    // Streaming fetch, one instruction per cycle
    push_seq(32'h1C00_0000, 8);
    rel    = cyc;
    run_en = 1'b1;
    idle(1);
    check("first_req",  65'(s_req),  65'(1));
    check("first_addr", 65'(s_addr), 65'(32'h1C00_0000));
    drain("seq_drain", 40);
    check("first_latency", 65'(first_pop - rel), 65'(2));
    check("throughput",    65'(last_pop - first_pop), 65'(7));

    // ID stalled: queue holds exactly FQ_DEPTH entries, then drains in order
    allow_en = 1'b0;
    branch(32'h1C00_1000);
    acc_log.delete();
    idle(20);
    check("bp_accepts",  65'(acc_log.size()), 65'(4));
    check("bp_first",    65'(acc_at(0)), 65'(32'h1C00_1000));
    check("bp_last",     65'(acc_at(3)), 65'(32'h1C00_100C));
    check("bp_req_low",  65'(s_req),   65'(0));
    check("bp_valid",    65'(s_valid), 65'(1));
    allow_en = 1'b1;
    push_seq(32'h1C00_1000, 6);
    drain("bp_drain", 40);

    // Redirect with two requests outstanding
    idle(10);
    rsp_en = 1'b0;
    branch(32'h1C00_2000);
    idle(4);
    check("two_outstanding", 65'(mem_q.size()), 65'(2));
    rsp_en = 1'b1;
    branch(32'h1C00_0100);
    acc_log.delete();
    push_seq(32'h1C00_0100, 6);
    drain("redir_drain", 40);
    check("redir_first_acc", 65'(acc_at(0)), 65'(32'h1C00_0100));

    // Redirect while a request is held without addr_ok
    idle(10);
    accept_en = 1'b0;
    branch(32'h1C00_0010);
    idle(3);
    branch(32'h1C00_0200);
    idle(2);
    check("held_req",  65'(s_req),  65'(1));
    check("held_addr", 65'(s_addr), 65'(32'h1C00_0010));
    acc_log.delete();
    accept_en = 1'b1;
    push_seq(32'h1C00_0200, 5);
    drain("held_drain", 40);
    check("held_acc0", 65'(acc_at(0)), 65'(32'h1C00_0010));
    check("held_acc1", 65'(acc_at(1)), 65'(32'h1C00_0200));

    // Misaligned target yields a single ADEF bubble, then fetch stops
    branch(32'h1C00_0302);
    acc_log.delete();
    sb.push_back({1'b1, 32'h0, 32'h1C00_0302});
    drain("adef_drain", 40);
    idle(8);
    check("adef_no_req",   65'(acc_log.size()), 65'(0));
    check("adef_req_low",  65'(s_req),   65'(0));
    check("adef_no_valid", 65'(s_valid), 65'(0));
    branch(32'h1C00_0400);
    push_seq(32'h1C00_0400, 3);
    drain("resume_drain", 40);

    // data_ok, addr_ok and br_taken together
    idle(10);
    rsp_en = 1'b0;
    branch(32'h1C00_3000);
    idle(4);
    check("collide_setup", 65'(mem_q.size()), 65'(2));
    rsp_en = 1'b1;
    fired  = 1'b0;
    for (int k = 0; k < 10 && !fired; k++) cycle(1'b0, 32'h1C00_4000, 1'b1, fired);
    check("collide_fired", 65'(fired), 65'(1));
    idle(1);
    check("collide_flushed", 65'(s_valid), 65'(0));
    push_seq(32'h1C00_4000, 4);
    drain("collide_drain", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
